// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL-side and status signal bundle for pll_lock_sequencer
//
// Purpose: groups the PLL handshake (reset out, raw lock in) together with the
//          restart request and the published status of the lock sequencer.
// Signals:
//    pll_locked  raw PLL locked flag, asynchronous to refclk
//    restart     single-cycle request to re-run the sequence
//    pll_rst     reset to the PLL wrapper
//    clk_ready   PLL output locked and qualified
//    fail        retries exhausted
//    lock_lost   sticky, lock dropped while running
//    retry_cnt   retries used in the current sequence
// Modports:
//    slave   the sequencer (consumes pll_locked/restart, drives status)
//    master  the surrounding system / PLL side

interface pll_lock_sequencer_if;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic       clk_ready;
   logic       fail;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   modport slave (
      input  pll_locked,
      input  restart,
      output pll_rst,
      output clk_ready,
      output fail,
      output lock_lost,
      output retry_cnt
   );

   modport master (
      output pll_locked,
      output restart,
      input  pll_rst,
      input  clk_ready,
      input  fail,
      input  lock_lost,
      input  retry_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset and lock qualification sequencer with retry
//
// Purpose: pulses the PLL reset, synchronizes and qualifies the PLL locked flag,
//          retries on lock timeout and publishes a qualified clk_ready plus status.
//          Runs entirely in the refclk domain.
// Ports:
//    refclk  PLL reference clock, the only clock
//    rst     asynchronous active-high reset
//    bus     pll_lock_sequencer_if.slave: pll_locked, restart in;
//            pll_rst, clk_ready, fail, lock_lost, retry_cnt out
// Build option:
//    PLL_SEQ_AUTO_RELOCK_EN  defined: lock loss in RUN re-runs the sequence.
//                            undefined: lock loss in RUN parks in HALT until restart.

module pll_lock_sequencer #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 70000,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int MAX_RETRIES      = 7,
   parameter int CNT_W            = 17
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_sequencer_if.slave   bus
);

   localparam logic [2:0] ST_RST_ASSERT = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
   localparam logic [2:0] ST_STABLE     = 3'd2;
   localparam logic [2:0] ST_RUN        = 3'd3;
   localparam logic [2:0] ST_FAIL       = 3'd4;
   localparam logic [2:0] ST_HALT       = 3'd5;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             sync1;
   logic             lock_s;
   logic [3:0]       retry_nxt;
   logic             lost_nxt;

   always_comb begin
      state_nxt = state;
      retry_nxt = bus.retry_cnt;
      lost_nxt  = bus.lock_lost;
      case (state)
         ST_RST_ASSERT: begin
            if (cnt == RST_LAST)
               state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock is tested first so it wins over a coincident timeout.
            if (lock_s)
               state_nxt = ST_STABLE;
            else if (cnt == TIMEOUT_LAST) begin
               if (bus.retry_cnt == RETRY_MAX)
                  state_nxt = ST_FAIL;
               else begin
                  retry_nxt = bus.retry_cnt + 4'd1;
                  state_nxt = ST_RST_ASSERT;
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s)
               state_nxt = ST_WAIT_LOCK;
            else if (cnt == STABLE_LAST)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // restart is deliberately not looked at here, even on the loss cycle.
            if (!lock_s) begin
               lost_nxt = 1'b1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               retry_nxt = 4'd0;
               state_nxt = ST_RST_ASSERT;
`else
               state_nxt = ST_HALT;
`endif
            end
         end
         ST_FAIL, ST_HALT: begin
            if (bus.restart) begin
               retry_nxt = 4'd0;
               lost_nxt  = 1'b0;
               state_nxt = ST_RST_ASSERT;
            end
         end
         default: state_nxt = ST_RST_ASSERT;
      endcase
   end

   // Outputs are decoded from state_nxt so they move on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1         <= 1'b0;
         lock_s        <= 1'b0;
         state         <= ST_RST_ASSERT;
         cnt           <= '0;
         bus.pll_rst   <= 1'b1;
         bus.clk_ready <= 1'b0;
         bus.fail      <= 1'b0;
         bus.lock_lost <= 1'b0;
         bus.retry_cnt <= 4'd0;
      end else begin
         sync1         <= bus.pll_locked;
         lock_s        <= sync1;
         state         <= state_nxt;
         // No state loops back to itself, so any change of state is an entry.
         cnt           <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         bus.pll_rst   <= (state_nxt == ST_RST_ASSERT) || (state_nxt == ST_FAIL);
         bus.clk_ready <= (state_nxt == ST_RUN);
         bus.fail      <= (state_nxt == ST_FAIL);
         bus.lock_lost <= lost_nxt;
         bus.retry_cnt <= retry_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer

module tb_pll_lock_sequencer;

   localparam int RST_PULSE  = 4;
   localparam int TIMEOUT    = 20;
   localparam int STABLE     = 8;
   localparam int MAXR       = 2;

   logic refclk;
   logic rst;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer #(
      .RST_PULSE_CYC    (RST_PULSE),
      .LOCK_TIMEOUT_CYC (TIMEOUT),
      .LOCK_STABLE_CYC  (STABLE),
      .MAX_RETRIES      (MAXR),
      .CNT_W            (5)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // {pll_rst, clk_ready, fail, lock_lost, retry_cnt}
   logic [7:0] dut_o;
   assign dut_o = {bus.pll_rst, bus.clk_ready, bus.fail, bus.lock_lost, bus.retry_cnt};

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // Reference model: phases named after what the PLL is doing, time measured as
   // cycles already spent in the phase, and the synchronizer as a two-stage delay.
   typedef enum int {P_PULSE, P_WAIT, P_QUAL, P_RUN, P_FAILED, P_HALTED} phase_t;
   phase_t m_phase;
   int     m_elapsed;
   bit     m_s1, m_ls;
   int     m_retry;
   bit     m_lost;

   task automatic model_reset();
      m_phase = P_PULSE; m_elapsed = 0; m_s1 = 0; m_ls = 0; m_retry = 0; m_lost = 0;
   endtask

   task automatic model_edge(input bit locked, input bit req);
      phase_t nxt;
      int     spent;
      nxt   = m_phase;
      spent = m_elapsed + 1;
      case (m_phase)
         P_PULSE:  if (spent == RST_PULSE) nxt = P_WAIT;
         P_WAIT: begin
            if (m_ls) nxt = P_QUAL;
            else if (spent == TIMEOUT) begin
               if (m_retry == MAXR) nxt = P_FAILED;
               else begin m_retry++; nxt = P_PULSE; end
            end
         end
         P_QUAL: begin
            if (!m_ls) nxt = P_WAIT;
            else if (spent == STABLE) nxt = P_RUN;
         end
         P_RUN: begin
            if (!m_ls) begin
               m_lost = 1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               m_retry = 0;
               nxt = P_PULSE;
`else
               nxt = P_HALTED;
`endif
            end
         end
         default: begin
            if (req) begin m_retry = 0; m_lost = 0; nxt = P_PULSE; end
         end
      endcase
      m_elapsed = (nxt != m_phase) ? 0 : spent;
      m_phase   = nxt;
      m_ls      = m_s1;
      m_s1      = locked;
   endtask

   function automatic logic [7:0] model_o();
      logic [3:0] r;
      r = 4'(m_retry);
      return {(m_phase == P_PULSE) || (m_phase == P_FAILED), m_phase == P_RUN,
              m_phase == P_FAILED, m_lost, r};
   endfunction

   // Drives inputs away from the edge, clocks once, then samples 1 time unit later.
   task automatic tick(input bit locked, input bit req);
      bus.pll_locked = locked;
      bus.restart    = req;
      @(posedge refclk);
      model_edge(locked, req);
      cyc++;
      #1;
      check("model", dut_o, model_o());
   endtask

   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      bus.restart    = 1'b0;
      model_reset();
      repeat (2) @(negedge refclk);
      rst = 1'b0;
      cyc = 0;
      #1;
      check("reset_state", dut_o, 8'b1000_0000);
   endtask

   typedef struct {
      bit         do_rst;
      bit         locked;
      bit         restart;
      int         n;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rs, input bit l, input bit r, input int n, input logic [7:0] e);
      vec_t v;
      v.do_rst = rs; v.locked = l; v.restart = r; v.n = n; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit lvl;
      int len;
      int total;
      rst            = 1'b1;
      bus.pll_locked = 1'b0;
      bus.restart    = 1'b0;
      model_reset();

      // clean bring-up: lock sampled from edge 10, ready at cycle 20
      add(1, 0, 0, 3,  8'b1000_0000);
      add(0, 0, 0, 1,  8'b0000_0000);
      add(0, 0, 0, 5,  8'b0000_0000);
      add(0, 1, 0, 10, 8'b0000_0000);
      add(0, 1, 0, 1,  8'b0100_0000);
      add(0, 1, 0, 10, 8'b0100_0000);
      // never lock: retries at 24 and 48, fail at 72, then restart
      add(1, 0, 0, 23, 8'b0000_0000);
      add(0, 0, 0, 1,  8'b1000_0001);
      add(0, 0, 0, 47, 8'b0000_0010);
      add(0, 0, 0, 1,  8'b1010_0010);
      add(0, 0, 0, 5,  8'b1010_0010);
      add(0, 0, 1, 1,  8'b1000_0000);
      add(0, 0, 0, 3,  8'b1000_0000);
      add(0, 0, 0, 1,  8'b0000_0000);
      // glitch after 5 qualified cycles: qualification restarts, ready at 27
      add(1, 0, 0, 9,  8'b0000_0000);
      add(0, 1, 0, 6,  8'b0000_0000);
      add(0, 0, 0, 1,  8'b0000_0000);
      add(0, 1, 0, 4,  8'b0000_0000);
      add(0, 1, 0, 6,  8'b0000_0000);
      add(0, 1, 0, 1,  8'b0100_0000);
      // lock seen on the last timeout cycle: lock wins, no retry
      add(1, 0, 0, 21, 8'b0000_0000);
      add(0, 1, 0, 3,  8'b0000_0000);
      add(0, 1, 0, 7,  8'b0000_0000);
      add(0, 1, 0, 1,  8'b0100_0000);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].locked, vecs[i].restart);
         check($sformatf("vec%0d", i), dut_o, vecs[i].exp);
      end

      // lock loss in RUN, with restart on the loss cycle
      do_reset();
      repeat (9) tick(0, 0);
      repeat (11) tick(1, 0);
      check("run_reached", dut_o, 8'b0100_0000);
      tick(0, 0);
      check("loss_edge1", dut_o, 8'b0100_0000);
      tick(0, 0);
      check("loss_edge2", dut_o, 8'b0100_0000);
      tick(0, 1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
      check("loss_relock", dut_o, 8'b1001_0000);
      repeat (3) tick(0, 0);
      check("relock_pulse", dut_o, 8'b1001_0000);
      tick(1, 0);
      check("relock_pulse_end", dut_o, 8'b0001_0000);
      for (int i = 0; i < 60 && !bus.clk_ready; i++) tick(1, 0);
      check("relock_ready", dut_o, 8'b0101_0000);
`else
      check("loss_halt", dut_o, 8'b0001_0000);
      repeat (3) tick(0, 0);
      check("halt_hold", dut_o, 8'b0001_0000);
      tick(1, 1);
      check("halt_restart", dut_o, 8'b1000_0000);
      for (int i = 0; i < 60 && !bus.clk_ready; i++) tick(1, 0);
      check("restart_ready", dut_o, 8'b0100_0000);
`endif

      // async reset mid-STABLE, no clock edge in between
      do_reset();
      repeat (9) tick(0, 0);
      repeat (5) tick(1, 0);
      check("in_stable", dut_o, 8'b0000_0000);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_stable", dut_o, 8'b1000_0000);
      do_reset();
      // async reset mid-RUN
      repeat (9) tick(0, 0);
      repeat (15) tick(1, 0);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_run", dut_o, 8'b1000_0000);

      // randomized lock behaviour against the model
      do_reset();
      total = 0;
      while (total < 3000) begin
         lvl = 1'($urandom_range(0, 1));
         len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 90);
         for (int k = 0; k < len; k++) tick(lvl, $urandom_range(0, 15) == 0);
         total += len;
         if ($urandom_range(0, 30) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
